// File: rtl/ysyx_23060077_icache_axi_bridge_pkg.sv
// Shared widths, AXI constants and FSM state type for the I-cache AXI refill bridge.
package ysyx_23060077_icache_axi_bridge_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } icb_state_e;

  // Address of the next 32-bit instruction beat in an INCR burst.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_beat_addr(
    input logic [AXI_ADDR_WIDTH-1:0] a
  );
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_23060077_axi_rlane_sel.sv
// Combinational 32-bit lane picker for the AXI R data bus (32- or 64-bit wide).
module ysyx_23060077_axi_rlane_sel #(
  parameter int AXI_DATA_W = 64
) (
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic                  hi_sel,
  output logic [31:0]           lane
);

  generate
    if (AXI_DATA_W == 64) begin : g_w64
      assign lane = hi_sel ? rdata[63:32] : rdata[31:0];
    end else begin : g_w32
      logic unused_sel;
      assign unused_sel = hi_sel;
      assign lane       = rdata[31:0];
    end
  endgenerate

endmodule

// File: rtl/ysyx_23060077_icache_axi_bridge.sv
// I-cache refill responder: turns each refill request into one AXI4 INCR read
// burst and streams 32-bit instruction beats back to the cache.
// Optional macro YSYX_23060077_ICB_RESP_CHECK_EN enables the sticky err_o
// check of rresp/rid/rlast on every accepted beat.
module ysyx_23060077_icache_axi_bridge
  import ysyx_23060077_icache_axi_bridge_pkg::*;
#(
  parameter int         AXI_DATA_W = 64,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      icache_r_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] icache_r_addr_i,
  input  logic [AXI_LEN_WIDTH-1:0]  icache_r_len_i,
  output logic                      icache_r_ready_o,
  output logic [31:0]               icache_r_data_o,
  output logic                      icache_r_last_o,
  output logic                      err_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
  output logic [3:0]                arid_o,
  output logic [AXI_LEN_WIDTH-1:0]  arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [AXI_DATA_W-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  input  logic [3:0]                rid_i
);

  icb_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_LEN_WIDTH-1:0]  len_q;
  logic [AXI_LEN_WIDTH-1:0]  beat_cnt_q;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr_q;

  logic        beat_fire;
  logic        beat_final;
  logic [31:0] lane_data;

  logic        vld_p1;
  logic        last_p1;
  logic [31:0] data_p1;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^icache_r_addr_i[1:0];

  assign beat_fire  = rvalid_i & rready_o;
  // beat_cnt is 8 bits; at len=255 the final compare is exact and the wrap
  // on that final increment is harmless because the FSM leaves R.
  assign beat_final = (beat_cnt_q == len_q);

  assign araddr_o  = addr_q;
  assign arlen_o   = len_q;
  assign arid_o    = AXI_ID;
  assign arsize_o  = SIZE_4B;
  assign arburst_o = BURST_INCR;

  assign icache_r_ready_o = vld_p1;
  assign icache_r_last_o  = last_p1;
  assign icache_r_data_o  = data_p1;

  ysyx_23060077_axi_rlane_sel #(
    .AXI_DATA_W(AXI_DATA_W)
  ) u_rlane_sel (
    .rdata (rdata_i),
    .hi_sel(beat_addr_q[2]),
    .lane  (lane_data)
  );

  // FSM state register; reset abandons any outstanding burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and AXI handshake outputs; rlast_i never steers sequencing.
  always_comb begin
    state_d   = state_q;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (icache_r_valid_i) state_d = ST_AR;
      end
      ST_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = ST_R;
      end
      ST_R: begin
        rready_o = 1'b1;
        if (rvalid_i && beat_final) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Hold here until the cache drops valid so a stale request cannot relaunch.
        if (!icache_r_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and per-beat counter / address tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      beat_addr_q <= '0;
    end else if (state_q == ST_IDLE && icache_r_valid_i) begin
      addr_q      <= {icache_r_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
      len_q       <= icache_r_len_i;
      beat_cnt_q  <= '0;
      beat_addr_q <= {icache_r_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
    end else if (beat_fire) begin
      beat_cnt_q  <= beat_cnt_q + 8'd1;
      beat_addr_q <= next_beat_addr(beat_addr_q);
    end
  end

  // ---- stage p1: beat delivered to the cache one cycle after the R handshake ----
  // Beat output register: one-cycle ready pulse, with last and data alongside.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= beat_fire;
      last_p1 <= beat_fire & beat_final;
      if (beat_fire) data_p1 <= lane_data;
    end
  end

`ifdef YSYX_23060077_ICB_RESP_CHECK_EN
  logic beat_err;
  logic err_q;

  assign beat_err = (rresp_i != RESP_OKAY) | (rid_i != AXI_ID) | (rlast_i != beat_final);
  assign err_o    = err_q;

  // Sticky error flag; data still flows and the burst completes normally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (beat_fire && beat_err) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp_i, rid_i, rlast_i};
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060077_icache_axi_bridge.sv
// Directed bench for the I-cache AXI refill bridge (64-bit R data bus).
module tb_ysyx_23060077_icache_axi_bridge;

  logic        clock;
  logic        reset;
  logic        icache_r_valid_i;
  logic [31:0] icache_r_addr_i;
  logic [7:0]  icache_r_len_i;
  logic        icache_r_ready_o;
  logic [31:0] icache_r_data_o;
  logic        icache_r_last_o;
  logic        err_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [63:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic [3:0]  rid_i;

  ysyx_23060077_icache_axi_bridge #(.AXI_DATA_W(64), .AXI_ID(4'd0)) dut (
    .clock(clock), .reset(reset),
    .icache_r_valid_i(icache_r_valid_i), .icache_r_addr_i(icache_r_addr_i),
    .icache_r_len_i(icache_r_len_i), .icache_r_ready_o(icache_r_ready_o),
    .icache_r_data_o(icache_r_data_o), .icache_r_last_o(icache_r_last_o),
    .err_o(err_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arid_o(arid_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .rvalid_i(rvalid_i),
    .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rid_i(rid_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [63:0] rword   [0:255];
  logic [1:0]  rresp_v [0:255];
  logic [31:0] got_data[0:255];
  logic        got_last[0:255];
  logic        obs_ready[0:63];
  int          nbeats;
  logic        timeout, ar_bad, r_bad, early_ready, post_ready;
  logic [31:0] got_araddr;
  logic [7:0]  got_arlen;

`ifdef YSYX_23060077_ICB_RESP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Place a 32-bit instruction in the lane selected by address bit 2; junk in the other lane.
  function automatic logic [63:0] build_word(input logic [31:0] a, input logic [31:0] val);
    return a[2] ? {val, 32'hDEAD_BEEF} : {32'hDEAD_BEEF, val};
  endfunction

  // AXI slave model: drives one refill request, AR with delay, and R beats gated by pat.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                           input int ar_delay, input logic [15:0] pat, input int max_beats);
    int  w, k, c;
    logic v;
    timeout = 0; ar_bad = 0; r_bad = 0; early_ready = 0; post_ready = 0; nbeats = 0;
    for (int i = 0; i < 64; i++) obs_ready[i] = 1'b0;
    icache_r_valid_i = 1'b1;
    icache_r_addr_i  = addr;
    icache_r_len_i   = len;
    tick();
    w = 0;
    while (!arvalid_o && w < 20) begin tick(); w++; end
    if (!arvalid_o) begin timeout = 1; return; end
    got_araddr = araddr_o;
    got_arlen  = arlen_o;
    // Junk R traffic while in AR must be ignored.
    rvalid_i = 1'b1; rdata_i = 64'hBAD0_BAD0_BAD0_BAD0; rlast_i = 1'b1;
    for (int d = 0; d < ar_delay; d++) begin
      tick();
      if (!arvalid_o || araddr_o !== got_araddr || arlen_o !== got_arlen) ar_bad = 1;
      if (icache_r_ready_o) early_ready = 1;
    end
    rvalid_i = 1'b0; rlast_i = 1'b0;
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    if (icache_r_ready_o) early_ready = 1;
    k = 0; c = 0;
    while (k <= int'(len) && k < max_beats && c < 600) begin
      v = (c < 16) ? pat[c] : 1'b1;
      rvalid_i = v;
      rdata_i  = rword[k];
      rresp_i  = rresp_v[k];
      rlast_i  = (k == int'(len));
      rid_i    = 4'd0;
      if (rready_o !== 1'b1) r_bad = 1;
      tick();
      if (c < 64) obs_ready[c] = icache_r_ready_o;
      if (icache_r_ready_o && nbeats < 256) begin
        got_data[nbeats] = icache_r_data_o;
        got_last[nbeats] = icache_r_last_o;
        nbeats++;
      end
      if (v) k++;
      c++;
    end
    rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
    if (k <= int'(len) && k < max_beats) timeout = 1;
    if (max_beats > int'(len)) begin
      tick();
      post_ready = icache_r_ready_o;
    end
  endtask

  task automatic end_request();
    icache_r_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++; if (arvalid_o !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", arvalid_o); end
    total++; if (rready_o !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", rready_o); end
    total++; if (icache_r_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", icache_r_ready_o); end
    total++; if (icache_r_last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", icache_r_last_o); end
    total++; if (icache_r_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", icache_r_data_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (arsize_o !== 3'b010) begin bad++; $display("FAIL arsize got=%b exp=010", arsize_o); end
    total++; if (arburst_o !== 2'b01) begin bad++; $display("FAIL arburst got=%b exp=01", arburst_o); end
    total++; if (arid_o !== 4'd0) begin bad++; $display("FAIL arid got=%h exp=0", arid_o); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_burst_len3();
    for (int k = 0; k < 4; k++) rword[k] = build_word(32'h3000_0010 + 32'(4 * k), 32'hA0 + 32'(k));
    run_burst(32'h3000_0010, 8'd3, 2, 16'hFFFF, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL len3_timeout got=%b exp=0", timeout); end
    total++; if (got_araddr !== 32'h3000_0010) begin bad++; $display("FAIL len3_araddr got=%h exp=30000010", got_araddr); end
    total++; if (got_arlen !== 8'd3) begin bad++; $display("FAIL len3_arlen got=%0d exp=3", got_arlen); end
    total++; if (ar_bad !== 1'b0) begin bad++; $display("FAIL len3_ar_stable got=%b exp=0", ar_bad); end
    total++; if (r_bad !== 1'b0) begin bad++; $display("FAIL len3_rready got=%b exp=0", r_bad); end
    total++; if (early_ready !== 1'b0) begin bad++; $display("FAIL len3_rvalid_in_ar got=%b exp=0", early_ready); end
    total++; if (nbeats !== 4) begin bad++; $display("FAIL len3_nbeats got=%0d exp=4", nbeats); end
    for (int k = 0; k < 4; k++) begin
      total++; if (got_data[k] !== 32'hA0 + 32'(k)) begin bad++; $display("FAIL len3_data%0d got=%h exp=%h", k, got_data[k], 32'hA0 + 32'(k)); end
      total++; if (got_last[k] !== (k == 3)) begin bad++; $display("FAIL len3_last%0d got=%b exp=%b", k, got_last[k], (k == 3)); end
    end
    total++; if (post_ready !== 1'b0) begin bad++; $display("FAIL len3_ready_after_last got=%b exp=0", post_ready); end
    end_request();
  endtask

  task automatic test_single_beat();
    rword[0] = 64'h1111_2222_3333_4444;
    run_burst(32'h3000_0004, 8'd0, 0, 16'hFFFF, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL len0_timeout got=%b exp=0", timeout); end
    total++; if (got_araddr !== 32'h3000_0004) begin bad++; $display("FAIL len0_araddr got=%h exp=30000004", got_araddr); end
    total++; if (got_arlen !== 8'd0) begin bad++; $display("FAIL len0_arlen got=%0d exp=0", got_arlen); end
    total++; if (nbeats !== 1) begin bad++; $display("FAIL len0_nbeats got=%0d exp=1", nbeats); end
    total++; if (got_data[0] !== 32'h1111_2222) begin bad++; $display("FAIL len0_data got=%h exp=11112222", got_data[0]); end
    total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL len0_last got=%b exp=1", got_last[0]); end
    total++; if (obs_ready[0] !== 1'b1) begin bad++; $display("FAIL len0_latency got=%b exp=1", obs_ready[0]); end
    end_request();
  endtask

  task automatic test_rvalid_gaps();
    logic [5:0] exp_rdy;
    exp_rdy = 6'b111001;
    for (int k = 0; k < 4; k++) rword[k] = build_word(32'h3000_0020 + 32'(4 * k), 32'hB0 + 32'(k));
    run_burst(32'h3000_0020, 8'd3, 1, 16'hFFF9, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL gaps_timeout got=%b exp=0", timeout); end
    for (int c = 0; c < 6; c++) begin
      total++; if (obs_ready[c] !== exp_rdy[c]) begin bad++; $display("FAIL gaps_ready_c%0d got=%b exp=%b", c, obs_ready[c], exp_rdy[c]); end
    end
    total++; if (nbeats !== 4) begin bad++; $display("FAIL gaps_nbeats got=%0d exp=4", nbeats); end
    for (int k = 0; k < 4; k++) begin
      total++; if (got_data[k] !== 32'hB0 + 32'(k)) begin bad++; $display("FAIL gaps_data%0d got=%h exp=%h", k, got_data[k], 32'hB0 + 32'(k)); end
      total++; if (got_last[k] !== (k == 3)) begin bad++; $display("FAIL gaps_last%0d got=%b exp=%b", k, got_last[k], (k == 3)); end
    end
    end_request();
  endtask

  task automatic test_back_to_back();
    rword[0] = build_word(32'h3000_0100, 32'hC0);
    rword[1] = build_word(32'h3000_0104, 32'hC1);
    run_burst(32'h3000_0100, 8'd1, 1, 16'hFFFF, 999);
    total++; if (nbeats !== 2) begin bad++; $display("FAIL b2b_first_nbeats got=%0d exp=2", nbeats); end
    // Valid stays high after the last beat: no relaunch allowed.
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (arvalid_o !== 1'b0) begin bad++; $display("FAIL b2b_stale_ar%0d got=%b exp=0", i, arvalid_o); end
    end
    end_request();
    rword[0] = build_word(32'h8000_0004, 32'hD0);
    run_burst(32'h8000_0007, 8'd0, 1, 16'hFFFF, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL b2b_second_timeout got=%b exp=0", timeout); end
    total++; if (got_araddr !== 32'h8000_0004) begin bad++; $display("FAIL b2b_araddr_align got=%h exp=80000004", got_araddr); end
    total++; if (got_data[0] !== 32'hD0) begin bad++; $display("FAIL b2b_data got=%h exp=000000d0", got_data[0]); end
    total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b exp=1", got_last[0]); end
    end_request();
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 4; k++) rword[k] = build_word(32'h3000_0200 + 32'(4 * k), 32'hE0 + 32'(k));
    run_burst(32'h3000_0200, 8'd3, 0, 16'hFFFF, 2);
    total++; if (nbeats !== 2) begin bad++; $display("FAIL rst_pre_nbeats got=%0d exp=2", nbeats); end
    total++; if (got_data[1] !== 32'hE1) begin bad++; $display("FAIL rst_pre_data got=%h exp=000000e1", got_data[1]); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (arvalid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_arvalid got=%b exp=0", arvalid_o); end
    total++; if (rready_o !== 1'b0) begin bad++; $display("FAIL rst_mid_rready got=%b exp=0", rready_o); end
    total++; if (icache_r_ready_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0", icache_r_ready_o); end
    total++; if (icache_r_last_o !== 1'b0) begin bad++; $display("FAIL rst_mid_last got=%b exp=0", icache_r_last_o); end
    total++; if (icache_r_data_o !== 32'h0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", icache_r_data_o); end
    icache_r_valid_i = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    rword[0] = build_word(32'h3000_0300, 32'hF0);
    rword[1] = build_word(32'h3000_0304, 32'hF1);
    run_burst(32'h3000_0300, 8'd1, 1, 16'hFFFF, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_post_timeout got=%b exp=0", timeout); end
    total++; if (nbeats !== 2) begin bad++; $display("FAIL rst_post_nbeats got=%0d exp=2", nbeats); end
    total++; if (got_data[0] !== 32'hF0 || got_data[1] !== 32'hF1) begin bad++; $display("FAIL rst_post_data got=%h,%h exp=000000f0,000000f1", got_data[0], got_data[1]); end
    total++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin bad++; $display("FAIL rst_post_last got=%b%b exp=01", got_last[0], got_last[1]); end
    end_request();
  endtask

  task automatic test_len255();
    int mism, nlast;
    for (int k = 0; k < 256; k++) rword[k] = build_word(32'h4000_0000 + 32'(4 * k), 32'h5500_0000 + 32'(k));
    run_burst(32'h4000_0000, 8'd255, 0, 16'hFFFF, 999);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL len255_timeout got=%b exp=0", timeout); end
    total++; if (nbeats !== 256) begin bad++; $display("FAIL len255_nbeats got=%0d exp=256", nbeats); end
    mism = 0; nlast = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (got_data[k] !== 32'h5500_0000 + 32'(k)) mism++;
      if (got_last[k] === 1'b1) nlast++;
    end
    total++; if (mism !== 0) begin bad++; $display("FAIL len255_data got=%0d_wrong exp=0", mism); end
    total++; if (nlast !== 1 || got_last[255] !== 1'b1) begin bad++; $display("FAIL len255_last got=%0d/%b exp=1/1", nlast, got_last[255]); end
    total++; if (post_ready !== 1'b0) begin bad++; $display("FAIL len255_no_extra_beat got=%b exp=0", post_ready); end
    end_request();
  endtask

  task automatic test_resp_error();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", err_o); end
    for (int k = 0; k < 4; k++) rword[k] = build_word(32'h3000_0400 + 32'(4 * k), 32'h10 + 32'(k));
    rresp_v[1] = 2'b10;
    run_burst(32'h3000_0400, 8'd3, 0, 16'hFFFF, 999);
    rresp_v[1] = 2'b00;
    total++; if (err_o !== ERR_EXP) begin bad++; $display("FAIL err_after_burst got=%b exp=%b", err_o, ERR_EXP); end
    total++; if (nbeats !== 4) begin bad++; $display("FAIL err_nbeats got=%0d exp=4", nbeats); end
    total++; if (got_data[1] !== 32'h11 || got_last[3] !== 1'b1) begin bad++; $display("FAIL err_forward got=%h/%b exp=00000011/1", got_data[1], got_last[3]); end
    end_request();
    repeat (3) tick();
    total++; if (err_o !== ERR_EXP) begin bad++; $display("FAIL err_sticky got=%b exp=%b", err_o, ERR_EXP); end
  endtask

  initial begin
    reset = 1'b1;
    icache_r_valid_i = 1'b0; icache_r_addr_i = '0; icache_r_len_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    rlast_i = 1'b0; rid_i = 4'd0;
    for (int k = 0; k < 256; k++) begin rword[k] = '0; rresp_v[k] = 2'b00; end
    test_reset();
    test_burst_len3();
    test_single_beat();
    test_rvalid_gaps();
    test_back_to_back();
    test_reset_mid_burst();
    test_len255();
    test_resp_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
